// File: rtl/rooth_inst_loader.sv
// ============================================================================
// Module   : rooth_inst_loader
// Brief    : Boot loader; streams a count-prefixed little-endian image into
//            instruction memory and holds the core in reset until loaded.
//            Optional trailing checksum enabled by LOADER_CHECKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rooth_inst_loader #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_hdr   = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_write = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] c_st_chk   = 3'd4;
`endif
    localparam logic [2:0] c_st_done  = 3'd5;
    localparam logic [2:0] c_st_error = 3'd6;

    localparam logic [32:0] c_cap = 33'd1 << MEM_AW;

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [2:0]      w_fin_state;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_word;
    logic [31:0]     r_count;
    logic [MEM_AW:0] r_index;
    logic [MEM_AW:0] w_index_inc;
    logic [31:0]     w_next_word;
    logic            w_accept;
    logic            w_last_byte;
    logic            w_start_ok;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]     r_sum;
`endif

    assign w_accept    = s_valid && s_ready;
    assign w_last_byte = w_accept && (r_byte_cnt == 2'd3);
    // Bytes shift in from the top so the first byte lands in bits 7:0.
    assign w_next_word = {s_data, r_word[31:8]};
    assign w_index_inc = r_index + 1'b1;
    assign w_start_ok  = start && ((r_state == c_st_idle) || (r_state == c_st_done) ||
                                   (r_state == c_st_error));

`ifdef LOADER_CHECKSUM_EN
    assign w_fin_state = c_st_chk;
`else
    assign w_fin_state = c_st_done;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle, c_st_done, c_st_error: begin
                if (w_start_ok) w_next_state = c_st_hdr;
            end
            c_st_hdr: begin
                if (w_last_byte) begin
                    if (w_next_word == 32'd0)
                        w_next_state = w_fin_state;
                    else if ({1'b0, w_next_word} > c_cap)
                        w_next_state = c_st_error;
                    else
                        w_next_state = c_st_data;
                end
            end
            c_st_data: begin
                if (w_last_byte) w_next_state = c_st_write;
            end
            c_st_write: begin
                if (32'(w_index_inc) == r_count)
                    w_next_state = w_fin_state;
                else
                    w_next_state = c_st_data;
            end
`ifdef LOADER_CHECKSUM_EN
            c_st_chk: begin
                if (w_last_byte)
                    w_next_state = (w_next_word == r_sum) ? c_st_done : c_st_error;
            end
`endif
            default: w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_byte_cnt <= 2'd0;
            r_word     <= 32'd0;
            r_count    <= 32'd0;
            r_index    <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= 32'd0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_start_ok) begin
                r_byte_cnt <= 2'd0;
                r_word     <= 32'd0;
                r_index    <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_sum      <= 32'd0;
`endif
            end
            if (w_accept) begin
                r_word     <= w_next_word;
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if ((r_state == c_st_hdr) && (r_byte_cnt == 2'd3))
                    r_count <= w_next_word;
            end
            if (r_state == c_st_write) begin
                r_index <= w_index_inc;
`ifdef LOADER_CHECKSUM_EN
                r_sum   <= r_sum + r_word;
`endif
            end
        end
    end

    // Everything below decodes registered state only; s_valid never reaches s_ready.
    assign s_ready    = (r_state == c_st_hdr) || (r_state == c_st_data)
`ifdef LOADER_CHECKSUM_EN
                        || (r_state == c_st_chk)
`endif
                        ;
    assign mem_we     = (r_state == c_st_write);
    assign mem_addr   = r_index[MEM_AW-1:0];
    assign mem_wdata  = r_word;
    assign core_rst_n = (r_state == c_st_done);
    assign done       = (r_state == c_st_done);
    assign err        = (r_state == c_st_error);
    assign busy       = s_ready || (r_state == c_st_write);

endmodule

`default_nettype wire
